// File: rtl/digit_frame_pkg.sv
// Shared types and constants for the 4x4 character PWM frame decoder.
package digit_frame_pkg;

   localparam int unsigned DEF_N_PIX   = 16;
   localparam int unsigned DEF_REF_IDX = 3;

   // Expected bitmaps of decoded characters; add further letters as they are characterised.
   localparam logic [15:0] CHAR_A = 16'h9F8F;
   localparam logic [15:0] CHAR_X = 16'h9679;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_EMIT    = 2'd2
   } dfd_state_e;

endpackage

// File: rtl/pix_sync.sv
// Parameterised-width two-flop synchroniser for asynchronous pixel lines.
module pix_sync #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/digit_frame_decoder.sv
// Recovers a static character bitmap from phase-modulated pixel PWM lines by
// majority-voting each pixel's level over a window of reference rising edges.
module digit_frame_decoder
   import digit_frame_pkg::*;
#(
   parameter int unsigned N_PIX   = DEF_N_PIX,
   parameter int unsigned REF_IDX = DEF_REF_IDX,
   parameter int unsigned N_EDGES = 8,
   parameter int unsigned TIMEOUT = 2097152
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_PIX-1:0] digit_in,
   output logic [N_PIX-1:0] frame,
   output logic             frame_clean,
   output logic             frame_valid,
   input  logic             frame_ready,
   output logic             timeout
);

   localparam int unsigned CW = $clog2(N_EDGES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT);

   localparam logic [CW-1:0] EDGE_LAST = CW'(N_EDGES - 1);
   localparam logic [CW-1:0] EDGE_FULL = CW'(N_EDGES);
   localparam logic [CW-1:0] EDGE_HALF = CW'(N_EDGES / 2);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

   dfd_state_e       state_q, state_d;
   logic [N_PIX-1:0] pix_s;
   logic             ref_d_q, ref_d_d;
   logic             ref_edge;
   logic             window_done;
   logic             unanimous;

   logic [CW-1:0]    edge_cnt_q, edge_cnt_d;
   logic [CW-1:0]    match_q   [N_PIX];
   logic [CW-1:0]    match_d   [N_PIX];
   logic [CW-1:0]    match_inc [N_PIX];
   logic [N_PIX-1:0] vote;
   logic [TW-1:0]    tcnt_q, tcnt_d;
   logic [N_PIX-1:0] frame_q, frame_d;
   logic             clean_q, clean_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;
   logic             clear_cnt;

   pix_sync #(
      .W (N_PIX)
   ) u_pix_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (digit_in),
      .q     (pix_s)
   );

   assign ref_d_d     = pix_s[REF_IDX];
   assign ref_edge    = pix_s[REF_IDX] & ~ref_d_q;
   assign window_done = (state_q == ST_ACQUIRE) && en && ref_edge && (edge_cnt_q == EDGE_LAST);

   // Per-pixel counts including the current cycle, plus the vote and unanimity derived from them.
   always_comb begin
      unanimous = 1'b1;
      vote      = '0;
      for (int i = 0; i < int'(N_PIX); i++) begin
         match_inc[i] = match_q[i] + CW'(pix_s[i]);
         vote[i]      = (match_inc[i] > EDGE_HALF);
         if ((match_inc[i] != '0) && (match_inc[i] != EDGE_FULL)) begin
            unanimous = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (en) state_d = ST_ACQUIRE;
         end
         ST_ACQUIRE: begin
            if (!en)              state_d = ST_IDLE;
            else if (window_done) state_d = ST_EMIT;
         end
         ST_EMIT: begin
            // A falling en only takes effect once the pending frame is accepted.
            if (frame_ready) state_d = en ? ST_ACQUIRE : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      edge_cnt_d = edge_cnt_q;
      match_d    = match_q;
      tcnt_d     = tcnt_q;
      frame_d    = frame_q;
      clean_d    = clean_q;
      valid_d    = valid_q;
      timeout_d  = 1'b0;
      clear_cnt  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            clear_cnt = 1'b1;
            valid_d   = 1'b0;
         end
         ST_ACQUIRE: begin
            if (!en) begin
               clear_cnt = 1'b1;
            end else if (ref_edge) begin
               edge_cnt_d = edge_cnt_q + CW'(1);
               match_d    = match_inc;
               tcnt_d     = '0;
               if (window_done) begin
                  frame_d   = vote;
                  clean_d   = unanimous;
                  valid_d   = 1'b1;
                  clear_cnt = 1'b1;
               end
            end else if (tcnt_q == TO_LAST) begin
               timeout_d = 1'b1;
               clear_cnt = 1'b1;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         ST_EMIT: begin
            // Edges seen while holding a frame are deliberately dropped.
            clear_cnt = 1'b1;
            if (frame_ready) valid_d = 1'b0;
         end
         default: begin
            clear_cnt = 1'b1;
            valid_d   = 1'b0;
         end
      endcase

      if (clear_cnt) begin
         edge_cnt_d = '0;
         tcnt_d     = '0;
         for (int i = 0; i < int'(N_PIX); i++) begin
            match_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_d_q    <= 1'b0;
         edge_cnt_q <= '0;
         tcnt_q     <= '0;
         frame_q    <= '0;
         clean_q    <= 1'b0;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
         for (int i = 0; i < int'(N_PIX); i++) begin
            match_q[i] <= '0;
         end
      end else begin
         ref_d_q    <= ref_d_d;
         edge_cnt_q <= edge_cnt_d;
         tcnt_q     <= tcnt_d;
         frame_q    <= frame_d;
         clean_q    <= clean_d;
         valid_q    <= valid_d;
         timeout_q  <= timeout_d;
         for (int i = 0; i < int'(N_PIX); i++) begin
            match_q[i] <= match_d[i];
         end
      end
   end

   assign frame       = frame_q;
   assign frame_clean = clean_q;
   assign frame_valid = valid_q;
   assign timeout     = timeout_q;

endmodule

// File: doc/digit_frame_decoder.md
# digit_frame_decoder

Consumes the 16-bit pixel PWM bus from the character PWM generator and recovers the static 4x4 character bitmap. Each pixel toggles either in phase or in anti-phase with a reference pixel. The block classifies each pixel by phase over a window of reference edges, emits a 16-bit frame over a valid/ready handshake, and flags ambiguous frames and a missing reference. It sits directly downstream of the generator, ahead of the neuromorphic input bridge.

## Interface
- `N_PIX`, 16: number of pixel lines.
- `REF_IDX`, 3: index of the pixel that is always in phase; it is the phase reference.
- `N_EDGES`, 8: reference rising edges per frame window; must be at least 2.
- `TIMEOUT`, 2097152: maximum clocks between reference edges before an error.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  enables acquisition.
- `digit_in`  in  N_PIX  raw pixel lines, asynchronous to `clk`.
- `frame`  out  N_PIX  decoded bitmap; bit i = 1 means pixel i is in phase.
- `frame_clean`  out  1  every pixel was unanimous across the window.
- `frame_valid`  out  1  frame available.
- `frame_ready`  in  1  consumer accepts the frame.
- `timeout`  out  1  one-cycle pulse when the reference has stalled.

## Operation
- **Synchronisation:** every `digit_in` bit passes through an identical 2-flop synchroniser to give `pix_s`. A third stage on the reference bit gives `ref_d`.
- **Reference edge:** `ref_edge = pix_s[REF_IDX] & ~ref_d`.
- **State machine:** IDLE, ACQUIRE, EMIT.
  - IDLE: all counters are zero. Move to ACQUIRE on `en`=1.
  - ACQUIRE, on each `ref_edge`:
    - `edge_cnt` increments.
    - For every i, `match[i]` increments if `pix_s[i]`=1 in that cycle.
    - The timeout counter clears.
  - ACQUIRE, when the `N_EDGES`-th edge is counted:
    - Register `frame[i] = (match[i] > N_EDGES/2)`, using the counts including this edge.
    - Register `frame_clean` = 1 when every `match[i]` is 0 or `N_EDGES`.
    - Go to EMIT.
  - ACQUIRE, timeout: the counter counts cycles with no `ref_edge`. When it reaches `TIMEOUT-1`:
    - Pulse `timeout` for one cycle.
    - Clear all counters and stay in ACQUIRE.
  - ACQUIRE, `en`=0: go to IDLE next cycle and discard partial counts.
  - EMIT: hold `frame_valid`=1 with `frame` and `frame_clean` stable. Edges arriving in EMIT are ignored, not counted. When `frame_valid && frame_ready`:
    - Clear counters.
    - Go to ACQUIRE if `en`=1, else IDLE.
    - `en` falling during EMIT does not abort the handshake.
- **Counter widths:**
  - `match[i]` and `edge_cnt` are `$clog2(N_EDGES+1)` bits and never exceed `N_EDGES`.
  - The timeout counter is `$clog2(TIMEOUT)` bits and does not wrap.
- **Tie rule:** if `match[i]` equals exactly `N_EDGES/2`, `frame[i]` = 0 and `frame_clean` = 0.
- **Reference bit:** `frame[REF_IDX]` is always 1 for a running reference.
- **Constant pixels:** a pixel stuck at 0 decodes to 0; a pixel stuck at 1 decodes to 1. Both are clean.
- **Slow mode required:** input toggling at the `clk` rate, i.e. the generator's slow clock disabled, is unsupported. Its result is undefined but must not hang the FSM.

## Timing
- **Reset:** all outputs are 0, the state is IDLE, and the synchronisers are cleared.
- **Pin to edge:** from a reference rising edge at the pin to `ref_edge` is 3 cycles.
- **Frame latency:** `frame_valid` rises the cycle after the `ref_edge` that completes the window.
- **Back-to-back frames:** at most one frame is emitted per `N_EDGES` reference edges. With `frame_ready` tied high, `frame_valid` is a one-cycle pulse and counting resumes the next cycle; an edge that coincides with the accept cycle is not counted.
- **Skew:** pins must be skew-aligned to within one `clk` period. An in-phase pixel must read 1 in the `ref_edge` cycle.
- **Reset mid-operation:** asynchronous `rst_n` assertion clears everything immediately, including a pending `frame_valid`.

## Structure
- **Shared package `digit_frame_pkg`:**
  - State enum (IDLE/ACQUIRE/EMIT).
  - Default `N_PIX` and `REF_IDX`.
  - Expected bitmap constants: `CHAR_A`=16'h9F8F and `CHAR_X`=16'h9679. Add J/N entries here as they are decoded.
- **Sub-module `pix_sync`:** parameterised-width 2-flop synchroniser, reset by `rst_n`. Everything else stays in the top module.

## Test plan
- **Decode A:** reference square wave with 16-clk period; pixels in mask 16'h9F8F in phase, the rest inverted, `frame_ready`=1. Expect `frame`=16'h9F8F, `frame_clean`=1, `frame_valid` one cycle after the 8th `ref_edge`.
- **Decode X:** same stimulus with mask 16'h9679. Expect `frame`=16'h9679, `frame_clean`=1.
- **Backpressure:** `frame_ready`=0 for 200 cycles after `frame_valid`. Expect `frame_valid` and `frame` held stable. The next frame completes only after 8 further edges counted after acceptance.
- **Ambiguity:** pixel 5 in phase for 4 edges, then inverted for 4. Expect `frame[5]`=0 and `frame_clean`=0; other bits correct.
- **Timeout:** with `TIMEOUT`=64, stop the reference after 3 edges. Expect a single `timeout` pulse 64 cycles after the last `ref_edge`, counters cleared. The following 8 good edges yield a correct frame.
- **Abort/reset:** drop `en` after 5 edges and expect IDLE with no frame. Separately, assert `rst_n`=0 while `frame_valid`=1 and expect all outputs 0 immediately.
